// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-fed asynchronous serial transmitter (start, LSB-first data, optional parity, stop)
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [15:0]      frame_cnt
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TMAX    = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BMAX    = BW'(WIDTH - 1);
  localparam logic          HAS_PAR = (PARITY != 0);
  localparam logic          ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY_BIT,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q;
  logic [BW-1:0]    bit_idx_q;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q;
  logic             tx_q, tx_d;
  logic             tx_done_q;
  logic [15:0]      frame_cnt_q;
  logic             bit_end;
  logic             pop;
  logic             frame_end;

  assign bit_end    = (timer_q == TMAX);
  assign pop        = (state_q == IDLE) && tx_en && !fifo_empty;
  assign frame_end  = (state_q == STOP) && bit_end;

  assign fifo_rd_en = pop;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign tx_done    = tx_done_q;
  assign frame_cnt  = frame_cnt_q;

  // Next state, next shift-register contents and the next serial line level.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    tx_d    = 1'b1;

    case (state_q)
      IDLE:       if (pop) state_d = FETCH;
      FETCH:      state_d = START;
      START:      if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && (bit_idx_q == BMAX)) state_d = HAS_PAR ? PARITY_BIT : STOP;
      end
      PARITY_BIT: if (bit_end) state_d = STOP;
      STOP:       if (bit_end) state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    // Word is captured as FETCH exits; the register then shifts once per data bit.
    if (state_q == FETCH) begin
      shreg_d = fifo_dout;
    end else if ((state_q == DATA) && bit_end) begin
      shreg_d = shreg_q >> 1;
    end

    // Line level is registered, so it is chosen from the state being entered.
    case (state_d)
      START:      tx_d = 1'b0;
      DATA:       tx_d = shreg_d[0];
      PARITY_BIT: tx_d = par_q;
      default:    tx_d = 1'b1;
    endcase
  end

  // State register, serial line, completion pulse and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      tx_done_q <= frame_end;
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Bit timer restarts at every state change and every bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else if ((state_d != state_q) || bit_end) begin
      timer_q <= '0;
    end else if (state_q inside {START, DATA, PARITY_BIT, STOP}) begin
      timer_q <= timer_q + 1'b1;
    end else begin
      timer_q <= '0;
    end
  end

  // Data bit index; held at zero outside DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx_q <= '0;
    end else if (state_q != DATA) begin
      bit_idx_q <= '0;
    end else if (bit_end) begin
      bit_idx_q <= bit_idx_q + 1'b1;
    end
  end

  // Shift register and parity bit, both taken from the fetched word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      if (state_q == FETCH) par_q <= (^fifo_dout) ^ ODD_PAR;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with queue-based FIFO and frame model
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  tx_en;
  wire  [2:0]  empty_w, rd_w, tx_w, busy_w, done_w;
  wire  [15:0] cnt_w [3];
  logic [7:0]  dout_r [3];
  logic [7:0]  fq [3][$];
  int          rd_cnt [3];
  logic [15:0] exp_cnt [3];
  int          checks, passed, failed;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY(0)) u_dut0 (
    .clk(clk), .rst(rst), .tx_en(tx_en[0]), .fifo_empty(empty_w[0]), .fifo_dout(dout_r[0]),
    .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]), .frame_cnt(cnt_w[0]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en[1]), .fifo_empty(empty_w[1]), .fifo_dout(dout_r[1]),
    .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]), .frame_cnt(cnt_w[1]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_en(tx_en[2]), .fifo_empty(empty_w[2]), .fifo_dout(dout_r[2]),
    .fifo_rd_en(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]), .frame_cnt(cnt_w[2]));

  assign empty_w[0] = (fq[0].size() == 0);
  assign empty_w[1] = (fq[1].size() == 0);
  assign empty_w[2] = (fq[2].size() == 0);

  // FIFO read port model: registered data one cycle after the pop request.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i]) begin
        rd_cnt[i]++;
        if (fq[i].size() > 0) dout_r[i] <= fq[i].pop_front();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Serial frame as a bit list: start, data LSB first, optional parity, stop.
  function automatic int build_frame(input int pm, input logic [7:0] w, output logic [11:0] bits);
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = w[i];
    n = 9;
    if (pm == 1) begin
      bits[n] = ^w;
      n++;
    end else if (pm == 2) begin
      bits[n] = ~^w;
      n++;
    end
    bits[n] = 1'b1;
    return n + 1;
  endfunction

  task automatic wait_rd(input int d);
    int n;
    n = 0;
    #1;
    while (rd_w[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("d%0d_rd_en_seen", d), {31'd0, rd_w[d]}, 32'd1);
  endtask

  task automatic run_frame(input int d, input logic [7:0] w, input int drop_at);
    logic [11:0] bits;
    int          nb, r0;
    nb = build_frame(d, w, bits);
    r0 = rd_cnt[d];
    wait_rd(d);
    @(negedge clk);
    chk($sformatf("d%0d_fetch_tx", d), {31'd0, tx_w[d]}, 32'd1);
    chk($sformatf("d%0d_fetch_busy", d), {31'd0, busy_w[d]}, 32'd1);
    chk($sformatf("d%0d_fetch_done", d), {31'd0, done_w[d]}, 32'd0);
    for (int k = 0; k < nb * C; k++) begin
      @(negedge clk);
      if (k == drop_at) tx_en[d] = 1'b0;
      chk($sformatf("d%0d_w%02h_cyc%0d", d, w, k), {31'd0, tx_w[d]}, {31'd0, bits[k/C]});
    end
    @(negedge clk);
    exp_cnt[d] = exp_cnt[d] + 16'd1;
    chk($sformatf("d%0d_tx_done", d), {31'd0, done_w[d]}, 32'd1);
    chk($sformatf("d%0d_frame_cnt", d), {16'd0, cnt_w[d]}, {16'd0, exp_cnt[d]});
    chk($sformatf("d%0d_pops", d), rd_cnt[d] - r0, 32'd1);
    chk($sformatf("d%0d_idle_tx", d), {31'd0, tx_w[d]}, 32'd1);
  endtask

  task automatic idle_check(input int d, input int cycles, input string tag);
    int r0, bad;
    r0  = rd_cnt[d];
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0) bad++;
    end
    chk({tag, "_pops"}, rd_cnt[d] - r0, 32'd0);
    chk({tag, "_line"}, bad, 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    int         r;
    checks = 0;
    passed = 0;
    failed = 0;
    rst    = 1'b0;
    tx_en  = '0;
    for (int d = 0; d < 3; d++) exp_cnt[d] = 16'd0;

    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx_w[0]}, 32'd1);
    chk("rst_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("rst_done", {31'd0, done_w[0]}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_w[0]}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_w[0]}, 32'd0);
    rst = 1'b1;

    tx_en[0] = 1'b1;
    idle_check(0, 20, "empty");
    tx_en[0] = 1'b0;
    fq[0].push_back(8'hA5);
    idle_check(0, 20, "txen_low");

    tx_en[0] = 1'b1;
    run_frame(0, 8'hA5, -1);

    fq[0].push_back(8'h3C);
    fq[0].push_back(8'hC3);
    run_frame(0, 8'h3C, 3 * C);
    idle_check(0, 20, "drop_blocks");
    chk("drop_qlen", fq[0].size(), 32'd1);
    tx_en[0] = 1'b1;
    run_frame(0, 8'hC3, -1);

    fq[0].push_back(8'h01);
    fq[0].push_back(8'h02);
    fq[0].push_back(8'h03);
    r = rd_cnt[0];
    run_frame(0, 8'h01, -1);
    run_frame(0, 8'h02, -1);
    run_frame(0, 8'h03, -1);
    chk("b2b_pops", rd_cnt[0] - r, 32'd3);
    @(negedge clk);
    chk("b2b_busy_after", {31'd0, busy_w[0]}, 32'd0);
    chk("b2b_tx_after", {31'd0, tx_w[0]}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      fq[0].push_back(w);
      run_frame(0, w, -1);
    end

    for (int d = 1; d < 3; d++) begin
      tx_en[d] = 1'b1;
      fq[d].push_back(8'hA5);
      run_frame(d, 8'hA5, -1);
      for (int i = 0; i < 2; i++) begin
        w = 8'($urandom);
        fq[d].push_back(w);
        run_frame(d, w, -1);
      end
    end

    w = 8'($urandom) | 8'h08;
    fq[0].push_back(w);
    wait_rd(0);
    repeat (19) @(negedge clk);
    chk("pre_rst_bit3", {31'd0, tx_w[0]}, {31'd0, w[3]});
    #1 rst = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx_w[0]}, 32'd1);
    chk("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("midrst_cnt", {16'd0, cnt_w[0]}, 32'd0);
    chk("midrst_cnt_d1", {16'd0, cnt_w[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) exp_cnt[d] = 16'd0;
    chk("midrst_qlen", fq[0].size(), 32'd0);
    w = 8'($urandom);
    fq[0].push_back(w);
    run_frame(0, w, -1);

    @(negedge clk);
    force u_dut0.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release u_dut0.frame_cnt_q;
    exp_cnt[0] = 16'hFFFF;
    w = 8'($urandom);
    fq[0].push_back(w);
    run_frame(0, w, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
